seq_restoring_divider: RTL and testbench

- Sequential restoring divider; the inverse of the team's shift-add multiplier.
- Takes a 2N-bit dividend, such as a multiplier product, and an N-bit divisor.
- Returns an N-bit quotient and N-bit remainder, resolving one quotient bit per clock.
- Uses the same start/finish level handshake as the multiplier so both blocks share one controller sequence.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/seq_restoring_divider_if.sv | 41 ++++
 rtl/seq_bin2bcd.sv | 80 ++++++++
 rtl/seq_restoring_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Optional feature macro: DIVIDER_BCD_EN (adds a BCD output and a CONV state).
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   // Packed BCD width large enough for an n-bit binary value.
   function automatic int unsigned bcd_width(input int unsigned n);
      return ((n / 3) + 1) * 4;
   endfunction

   // Iteration counter width: must hold the value n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/finish handshake and operand/result bundle for the divider.
// With DIVIDER_BCD_EN defined the bundle also carries the packed BCD quotient.
interface seq_restoring_divider_if
   import divider_pkg::*;
#(
   parameter int unsigned N = 8
);

   logic             start;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
   logic [N-1:0]     quotient;
   logic [N-1:0]     remainder;
   logic             div_by_zero;
   logic             overflow;
   logic             finish;
`ifdef DIVIDER_BCD_EN
   logic [bcd_width(N)-1:0] bcd;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, div_by_zero, overflow, finish, bcd
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, div_by_zero, overflow, finish, bcd
   );
`else
   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, div_by_zero, overflow, finish
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, div_by_zero, overflow, finish
   );
`endif

endinterface

// File: rtl/seq_bin2bcd.sv
// Serial double-dabble binary-to-BCD converter, one input bit per edge.
// load captures bin and starts; busy is high while shifting; done_c marks the
// edge that completes the conversion; clear zeroes the result and aborts.
// Only compiled when DIVIDER_BCD_EN is defined.
`ifdef DIVIDER_BCD_EN
module seq_bin2bcd
   import divider_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    load,
   input  logic [N-1:0]            bin,
   output logic                    busy,
   output logic                    done_c,
   output logic [bcd_width(N)-1:0] bcd
);

   localparam int unsigned BW = bcd_width(N);
   localparam int unsigned CW = cnt_width(N);
   localparam int unsigned ND = BW / 4;

   logic [N-1:0]  sh_q, sh_d;
   logic [BW-1:0] bcd_q, bcd_d, adj;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   // Add 3 to every digit that is 5 or more before the next shift.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < int'(ND); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Next-state logic for the shifter.
   always_comb begin
      sh_d   = sh_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (clear) begin
         bcd_d  = '0;
         busy_d = 1'b0;
      end else if (load) begin
         sh_d   = bin;
         bcd_d  = '0;
         cnt_d  = CW'(N);
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d = BW'({adj, sh_q[N-1]});
         sh_d  = sh_q << 1;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_d = 1'b0;
      end
   end

   // Converter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done_c = busy_q && (cnt_q == CW'(1));
   assign busy   = busy_q;
   assign bcd    = bcd_q;

endmodule
`endif

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per edge, start/finish level handshake shared with the multiplier.
// Optional feature macro: DIVIDER_BCD_EN (BCD quotient via a CONV state).
module seq_restoring_divider
   import divider_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input logic                    clk,
   input logic                    reset,
   seq_restoring_divider_if.slave bus
);

   localparam int unsigned CW = cnt_width(N);

   state_t        state_q, state_d;
   // Partial remainder; its (N+1)th bit is always zero between iterations,
   // so only N bits are stored and the top bit is rebuilt by the shift.
   logic [N-1:0]  r_q, r_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  d_q, d_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;
   logic          ovf_q, ovf_d;
   logic          fin_q, fin_d;

   logic [N:0]    run_shift;
   logic          run_ge;
   logic [N-1:0]  run_r;
   logic [N-1:0]  run_q;
   logic [N-1:0]  hi_word;

`ifdef DIVIDER_BCD_EN
   logic conv_load_c;
   logic conv_clear_c;
   logic conv_busy;
   logic conv_done_c;
`endif

   // One restoring iteration at N+1 bits: shift, trial-subtract, set Q[0].
   assign run_shift = {r_q, q_q[N-1]};
   assign run_ge    = run_shift >= {1'b0, d_q};
   assign run_r     = run_ge ? N'(run_shift - {1'b0, d_q}) : run_shift[N-1:0];
   assign run_q     = {q_q[N-2:0], run_ge};
   assign hi_word   = bus.dividend[2*N-1:N];

   // Next-state and datapath/output next values.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      fin_d   = fin_q;
`ifdef DIVIDER_BCD_EN
      conv_load_c  = 1'b0;
      conv_clear_c = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            fin_d = 1'b0;
            if (bus.start) begin
               d_d   = bus.divisor;
               r_d   = hi_word;
               q_d   = bus.dividend[N-1:0];
               cnt_d = CW'(N);
               dbz_d = 1'b0;
               ovf_d = 1'b0;
`ifdef DIVIDER_BCD_EN
               conv_clear_c = 1'b1;
`endif
               if (bus.divisor == '0) begin
                  dbz_d   = 1'b1;
                  quo_d   = '1;
                  rem_d   = '0;
                  fin_d   = 1'b1;
                  state_d = DONE;
               end else if (hi_word >= bus.divisor) begin
                  ovf_d   = 1'b1;
                  quo_d   = '1;
                  rem_d   = '0;
                  fin_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            r_d   = run_r;
            q_d   = run_q;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quo_d = run_q;
               rem_d = run_r;
`ifdef DIVIDER_BCD_EN
               conv_load_c = 1'b1;
               state_d     = CONV;
`else
               fin_d   = 1'b1;
               state_d = DONE;
`endif
            end
         end
`ifdef DIVIDER_BCD_EN
         CONV: begin
            if (conv_done_c || !conv_busy) begin
               fin_d   = 1'b1;
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            fin_d = 1'b1;
            if (!bus.start) begin
               fin_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            fin_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         fin_q   <= fin_d;
      end
   end

`ifdef DIVIDER_BCD_EN
   // Converts the final quotient while the FSM sits in CONV.
   seq_bin2bcd #(.N(N)) u_bin2bcd (
      .clk    (clk),
      .reset  (reset),
      .clear  (conv_clear_c),
      .load   (conv_load_c),
      .bin    (run_q),
      .busy   (conv_busy),
      .done_c (conv_done_c),
      .bcd    (bus.bcd)
   );
`endif

   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;
   assign bus.finish      = fin_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (N=8): directed table,
// randomized operands against an arithmetic model, reset-abort and
// start-held-through-DONE sequences. Honours DIVIDER_BCD_EN.
module tb_seq_restoring_divider;
   import divider_pkg::*;

   localparam int unsigned N = 8;
`ifdef DIVIDER_BCD_EN
   localparam int unsigned LAT = 2 * N;
`else
   localparam int unsigned LAT = N;
`endif
   localparam int unsigned QMAX = (1 << N) - 1;

   logic clk;
   logic reset;

   seq_restoring_divider_if #(.N(N)) bus ();

   seq_restoring_divider #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int unsigned q;
      int unsigned r;
      int unsigned lat;
      int unsigned bcd;
      bit          dbz;
      bit          ovf;
   } res_t;

   typedef struct {
      int unsigned dd;
      int unsigned dv;
      int unsigned q;
      int unsigned r;
      bit          dbz;
      bit          ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int unsigned to_bcd(input int unsigned v);
      return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   // Plain arithmetic reference.
   function automatic res_t model(input int unsigned dd, input int unsigned dv);
      res_t e;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (dv == 0) begin
         e.dbz = 1'b1; e.q = QMAX; e.r = 0; e.lat = 0; e.bcd = 0;
      end else if (dd / dv > QMAX) begin
         e.ovf = 1'b1; e.q = QMAX; e.r = 0; e.lat = 0; e.bcd = 0;
      end else begin
         e.q = dd / dv; e.r = dd % dv; e.lat = LAT; e.bcd = to_bcd(dd / dv);
      end
      return e;
   endfunction

   // Launch one operation from IDLE, check the DONE results and latency,
   // then drop start for one edge and check finish falls with results held.
   task automatic run_and_check(input string name, input int unsigned dd,
                                input int unsigned dv, input res_t e);
      int unsigned edges;
      bus.dividend = (2*N)'(dd);
      bus.divisor  = N'(dv);
      bus.start    = 1'b1;
      @(posedge clk); #1;
      edges = 0;
      while (bus.finish !== 1'b1 && edges < 200) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({name, ".latency"}, edges, e.lat);
      chk({name, ".quotient"}, bus.quotient, e.q);
      chk({name, ".remainder"}, bus.remainder, e.r);
      chk({name, ".div_by_zero"}, bus.div_by_zero, e.dbz);
      chk({name, ".overflow"}, bus.overflow, e.ovf);
`ifdef DIVIDER_BCD_EN
      chk({name, ".bcd"}, bus.bcd, e.bcd);
`endif
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk({name, ".finish_drop"}, bus.finish, 0);
      chk({name, ".quotient_held"}, bus.quotient, e.q);
   endtask

   vec_t tbl [10];

   initial begin
      res_t e;
      int unsigned edges;
      int unsigned hi, lo, dv;

      tbl[0] = '{dd: 1000,  dv: 7,   q: 142, r: 6, dbz: 0, ovf: 0};
      tbl[1] = '{dd: 65025, dv: 255, q: 255, r: 0, dbz: 0, ovf: 0};
      tbl[2] = '{dd: 65280, dv: 255, q: 255, r: 0, dbz: 0, ovf: 1};
      tbl[3] = '{dd: 1234,  dv: 0,   q: 255, r: 0, dbz: 1, ovf: 0};
      tbl[4] = '{dd: 5,     dv: 9,   q: 0,   r: 5, dbz: 0, ovf: 0};
      tbl[5] = '{dd: 0,     dv: 1,   q: 0,   r: 0, dbz: 0, ovf: 0};
      tbl[6] = '{dd: 200,   dv: 3,   q: 66,  r: 2, dbz: 0, ovf: 0};
      tbl[7] = '{dd: 65535, dv: 1,   q: 255, r: 0, dbz: 0, ovf: 1};
      tbl[8] = '{dd: 255,   dv: 255, q: 1,   r: 0, dbz: 0, ovf: 0};
      tbl[9] = '{dd: 511,   dv: 2,   q: 255, r: 1, dbz: 0, ovf: 0};

      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #1;
      chk("reset.quotient", bus.quotient, 0);
      chk("reset.remainder", bus.remainder, 0);
      chk("reset.div_by_zero", bus.div_by_zero, 0);
      chk("reset.overflow", bus.overflow, 0);
      chk("reset.finish", bus.finish, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         e       = model(tbl[i].dd, tbl[i].dv);
         e.q     = tbl[i].q;
         e.r     = tbl[i].r;
         e.dbz   = tbl[i].dbz;
         e.ovf   = tbl[i].ovf;
         e.lat   = (tbl[i].dbz || tbl[i].ovf) ? 0 : LAT;
         run_and_check($sformatf("vec%0d", i), tbl[i].dd, tbl[i].dv, e);
      end

      // Randomized operands, biased towards non-overflowing cases.
      for (int i = 0; i < 150; i++) begin
         dv = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, QMAX);
         hi = $urandom_range(0, QMAX);
         if (dv != 0 && $urandom_range(0, 3) != 0) hi = $urandom_range(0, dv - 1);
         lo = $urandom_range(0, QMAX);
         run_and_check($sformatf("rnd%0d", i), (hi << N) | lo, dv, model((hi << N) | lo, dv));
      end

      // Async reset at RUN edge 4 aborts with nothing kept.
      bus.dividend = 16'd1000;
      bus.divisor  = 8'd7;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("abort.quotient", bus.quotient, 0);
      chk("abort.remainder", bus.remainder, 0);
      chk("abort.flags", {bus.div_by_zero, bus.overflow}, 0);
      chk("abort.finish", bus.finish, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort.finish_held", bus.finish, 0);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort.idle_finish", bus.finish, 0);
      chk("abort.no_partial", bus.quotient, 0);
      run_and_check("relaunch", 200, 3, model(200, 3));

      // Start held through DONE; operand changes mid-RUN are ignored.
      bus.dividend = 16'd1000;
      bus.divisor  = 8'd7;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      edges = 0;
      while (bus.finish !== 1'b1 && edges < 200) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 2) begin
            bus.dividend = 16'd200;
            bus.divisor  = 8'd3;
         end
      end
      chk("hold.latency", edges, LAT);
      chk("hold.quotient", bus.quotient, 142);
      chk("hold.remainder", bus.remainder, 6);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold.finish%0d", i), bus.finish, 1);
         chk($sformatf("hold.quotient%0d", i), bus.quotient, 142);
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("hold.drop_finish", bus.finish, 0);
      chk("hold.drop_quotient", bus.quotient, 142);
      chk("hold.drop_remainder", bus.remainder, 6);
      @(posedge clk); #1;
      chk("hold.idle_finish", bus.finish, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
